// File: rtl/pipeline_ctrl_pkg.sv
// pipeline_ctrl_pkg: shared forwarding codes, sequencer state encoding and a saturating-increment helper
package pipeline_ctrl_pkg;
  localparam logic [1:0] FWD_RF     = 2'd0;
  localparam logic [1:0] FWD_EXE    = 2'd1;
  localparam logic [1:0] FWD_MEM    = 2'd2;
  localparam logic [1:0] FWD_MEMDIN = 2'd3;
  typedef enum logic [1:0] {
    S_INIT  = 2'd0,
    S_RUN   = 2'd1,
    S_MWAIT = 2'd2,
    S_HALT  = 2'd3
  } state_e;
  function automatic logic [31:0] sat_inc32(input logic [31:0] v, input logic inc);
    return (inc && v != '1) ? v + 32'd1 : v;
  endfunction
endpackage

// File: rtl/pipeline_ctrl_fwd_unit.sv
// fwd_unit: combinational forwarding select for one ID-stage source operand
// Ports: addr_i operand register; exe_*/mem_* destination, write-enable and load flag of the
//   EXE and MEM producers; sel_o = FWD_RF/FWD_EXE/FWD_MEM/FWD_MEMDIN.
import pipeline_ctrl_pkg::*;
module fwd_unit (
  input  logic [4:0] addr_i,
  input  logic [4:0] exe_addr_i,
  input  logic       exe_wen_i,
  input  logic       exe_load_i,
  input  logic [4:0] mem_addr_i,
  input  logic       mem_wen_i,
  input  logic       mem_load_i,
  output logic [1:0] sel_o
);
  // A load in EXE has no data yet; the load-use stall covers it, so fall through to MEM.
  assign sel_o = addr_i == 5'd0 ? FWD_RF :
                 (addr_i == exe_addr_i && exe_wen_i && !exe_load_i) ? FWD_EXE :
                 (addr_i == mem_addr_i && mem_wen_i) ? (mem_load_i ? FWD_MEMDIN : FWD_MEM) :
                 FWD_RF;
endmodule

// File: rtl/pipeline_ctrl.sv
// pipeline_ctrl: 5-stage MIPS pipeline sequencer (stage clears/enables, forwarding, stalls, flushes)
// Ports: clk, rst (async, active-high); addr_rs/addr_rt + id_rs_used/id_rt_used from ID;
//   regw_addr_*/wb_wen_*/wb_data_src_* for the EXE and MEM producers; is_branch_exe/is_branch_mem;
//   mem_req/mem_ack from MEM. Outputs: if/id/exe/mem/wb _rst and _en, data_rs_ctrl/data_rt_ctrl,
//   ctrl_error (memory timeout, halted), stall_cnt/flush_cnt.
// Build option: define PIPE_PERF_CNT_EN to enable the saturating stall/flush counters; otherwise tied 0.
import pipeline_ctrl_pkg::*;
module pipeline_ctrl #(
  parameter int RST_HOLD    = 4,
  parameter int MEM_TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [4:0]  addr_rs,
  input  logic [4:0]  addr_rt,
  input  logic        id_rs_used,
  input  logic        id_rt_used,
  input  logic [4:0]  regw_addr_exe,
  input  logic        wb_wen_exe,
  input  logic        wb_data_src_exe,
  input  logic [4:0]  regw_addr_mem,
  input  logic        wb_wen_mem,
  input  logic        wb_data_src_mem,
  input  logic        is_branch_exe,
  input  logic        is_branch_mem,
  input  logic        mem_req,
  input  logic        mem_ack,
  output logic        if_rst,
  output logic        id_rst,
  output logic        exe_rst,
  output logic        mem_rst,
  output logic        wb_rst,
  output logic        if_en,
  output logic        id_en,
  output logic        exe_en,
  output logic        mem_en,
  output logic        wb_en,
  output logic [1:0]  data_rs_ctrl,
  output logic [1:0]  data_rt_ctrl,
  output logic        ctrl_error,
  output logic [31:0] stall_cnt,
  output logic [31:0] flush_cnt
);
  state_e     state_q, state_d;
  logic [3:0] hold_q, hold_d;
  logic [7:0] wait_q, wait_d;
  logic       load_use, mem_stall, br_any;
  logic [1:0] rs_sel, rt_sel;
  assign load_use = wb_wen_exe && wb_data_src_exe && regw_addr_exe != 5'd0 &&
                    ((id_rs_used && addr_rs == regw_addr_exe) || (id_rt_used && addr_rt == regw_addr_exe));
  assign br_any = is_branch_mem | is_branch_exe;
  always_comb begin
    state_d = state_q;
    hold_d = hold_q;
    wait_d = wait_q;
    {if_rst, id_rst, exe_rst, mem_rst, wb_rst} = '0;
    {if_en, id_en, exe_en, mem_en, wb_en} = '0;
    mem_stall = 1'b0;
    case (state_q)
      S_INIT: begin
        {if_rst, id_rst, exe_rst, mem_rst, wb_rst} = '1;
        hold_d = hold_q + 4'd1;
        if (hold_q == 4'(RST_HOLD - 1)) state_d = S_RUN;
      end
      S_RUN, S_MWAIT: begin
        // The stall takes effect in the very cycle the unacknowledged request appears.
        mem_stall = !mem_ack && (mem_req || state_q == S_MWAIT);
        if (mem_stall) begin
          wb_rst = 1'b1;
          if (state_q == S_MWAIT && wait_q == 8'(MEM_TIMEOUT)) state_d = S_HALT;
          else begin
            state_d = S_MWAIT;
            wait_d = state_q == S_RUN ? 8'd1 : wait_q + 8'd1;
          end
        end else begin
          state_d = S_RUN;
          wait_d = '0;
          {exe_en, mem_en, wb_en} = '1;
          // branch_mem loads the target PC; branch_exe and load-use hold it.
          if_en = is_branch_mem || !(is_branch_exe || load_use);
          id_en = br_any || !load_use;
          id_rst = br_any;
          exe_rst = br_any || load_use;
        end
      end
      default: ;
    endcase
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state_q <= S_INIT;
      hold_q <= '0;
      wait_q <= '0;
    end else begin
      state_q <= state_d;
      hold_q <= hold_d;
      wait_q <= wait_d;
    end
  fwd_unit u_fwd_rs (
    .addr_i(addr_rs), .exe_addr_i(regw_addr_exe), .exe_wen_i(wb_wen_exe), .exe_load_i(wb_data_src_exe),
    .mem_addr_i(regw_addr_mem), .mem_wen_i(wb_wen_mem), .mem_load_i(wb_data_src_mem), .sel_o(rs_sel)
  );
  fwd_unit u_fwd_rt (
    .addr_i(addr_rt), .exe_addr_i(regw_addr_exe), .exe_wen_i(wb_wen_exe), .exe_load_i(wb_data_src_exe),
    .mem_addr_i(regw_addr_mem), .mem_wen_i(wb_wen_mem), .mem_load_i(wb_data_src_mem), .sel_o(rt_sel)
  );
  assign data_rs_ctrl = state_q == S_INIT ? FWD_RF : rs_sel;
  assign data_rt_ctrl = state_q == S_INIT ? FWD_RF : rt_sel;
  assign ctrl_error = state_q == S_HALT;
`ifdef PIPE_PERF_CNT_EN
  logic        active;
  logic [31:0] stall_q, flush_q;
  // While sequencing, id_en low means load-use or memory stall; id_rst high means a branch flush.
  assign active = state_q == S_RUN || state_q == S_MWAIT;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      stall_q <= '0;
      flush_q <= '0;
    end else begin
      stall_q <= sat_inc32(stall_q, active && !id_en);
      flush_q <= sat_inc32(flush_q, active && id_rst);
    end
  assign stall_cnt = stall_q;
  assign flush_cnt = flush_q;
`else
  assign stall_cnt = '0;
  assign flush_cnt = '0;
`endif
endmodule
